// File: rtl/arb_pkg.sv
// Shared types and the round-robin pick function for the 4-way arbiter.
package arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned SEL_W   = 2;

  typedef logic [SEL_W-1:0] sel_t;

  // Output stage occupancy; FULL means the output register holds a word.
  typedef enum logic {
    StEmpty,
    StFull
  } out_state_e;

  // First set bit of req, searching from ptr upward with wrap.
  // Scanning from the farthest offset down lets the nearest one win last.
  function automatic sel_t rr_pick(input logic [NUM_REQ-1:0] req, input sel_t ptr);
    sel_t idx;
    rr_pick = ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = ptr + sel_t'(i);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/mux.sv
// 4:1 data multiplexer, purely combinational.
module mux #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_c,
  input  logic [WIDTH-1:0] i_d,
  input  logic [1:0]       i_sel,
  output logic [WIDTH-1:0] o_y
);

  // Select one of four words.
  always_comb begin
    o_y = i_a;
    unique case (i_sel)
      2'd0: o_y = i_a;
      2'd1: o_y = i_b;
      2'd2: o_y = i_c;
      2'd3: o_y = i_d;
      default: o_y = i_a;
    endcase
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing a 4:1 mux between four valid/ready requesters,
// feeding a single registered output stage with valid/ready handshake.
module mux_rr_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_REQ-1:0] i_valid,
  output logic [NUM_REQ-1:0] o_ready,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  input  logic [WIDTH-1:0]   i_c,
  input  logic [WIDTH-1:0]   i_d,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [WIDTH-1:0]   o_data,
  output sel_t               o_src
);

  out_state_e       state_q;
  sel_t             ptr_q;
  sel_t             src_q;
  logic [WIDTH-1:0] data_q;

  logic             load;
  logic             any_req;
  sel_t             win;
  logic [WIDTH-1:0] mux_y;

  // Load when the output register is empty or being drained this cycle.
  always_comb begin
    load    = (state_q == StEmpty) || i_ready;
    any_req = |i_valid;
    win     = rr_pick(i_valid, ptr_q);
    o_ready = '0;
    if (load && any_req) o_ready[win] = 1'b1;
  end

  mux #(
    .WIDTH (WIDTH)
  ) u_mux (
    .i_a   (i_a),
    .i_b   (i_b),
    .i_c   (i_c),
    .i_d   (i_d),
    .i_sel (win),
    .o_y   (mux_y)
  );

  // Output stage FSM and priority pointer; pointer moves only on a real grant.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StEmpty;
      ptr_q   <= '0;
      src_q   <= '0;
      data_q  <= '0;
    end else if (load) begin
      if (any_req) begin
        state_q <= StFull;
        data_q  <= mux_y;
        src_q   <= win;
        ptr_q   <= win + sel_t'(1);
      end else begin
        state_q <= StEmpty;
      end
    end
  end

  assign o_valid = (state_q == StFull);
  assign o_data  = data_q;
  assign o_src   = src_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed self-checking bench for mux_rr_arbiter.
module tb_mux_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] valid;
  logic [3:0] ready_o;
  logic [7:0] a, b, c, d;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] data;
  logic [1:0] src;

  int n_checks;
  int n_errs;

  mux_rr_arbiter #(
    .WIDTH (8)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (valid),
    .o_ready (ready_o),
    .i_a     (a),
    .i_b     (b),
    .i_c     (c),
    .i_d     (d),
    .o_valid (out_valid),
    .i_ready (out_ready),
    .o_data  (data),
    .o_src   (src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_errs    = 0;
    rst_n     = 1'b0;
    valid     = '0;
    out_ready = 1'b0;
    a = 8'd0; b = 8'd0; c = 8'd0; d = 8'd0;
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_src", 32'(src), 32'd0);
    check("rst_ready", 32'(ready_o), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Single requester c.
    valid = 4'b0100; c = 8'd3; out_ready = 1'b1;
    #1;
    check("single_oready", 32'(ready_o), 32'b0100);
    step();
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_data", 32'(data), 32'd3);
    check("single_src", 32'(src), 32'd2);

    // Drain to idle; data holds.
    valid = 4'b0000;
    #1;
    check("drain_oready", 32'(ready_o), 32'd0);
    step();
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_data", 32'(data), 32'd3);

    // Wrap and skip from ptr=3 with a and b requesting.
    valid = 4'b0011; a = 8'h11; b = 8'h22;
    #1;
    check("wrap_oready", 32'(ready_o), 32'b0001);
    step();
    check("wrap_data0", 32'(data), 32'h11);
    check("wrap_src0", 32'(src), 32'd0);
    valid = 4'b0010;
    #1;
    check("wrap_oready1", 32'(ready_o), 32'b0010);
    step();
    check("wrap_data1", 32'(data), 32'h22);
    check("wrap_src1", 32'(src), 32'd1);
    valid = 4'b0000;
    step();
    check("wrap_idle", 32'(out_valid), 32'd0);

    // Load a word from ptr=2, then hold under backpressure and reset mid-FULL.
    a = 8'd1; b = 8'd2; c = 8'd3; d = 8'd4;
    valid = 4'b1111; out_ready = 1'b0;
    step();
    check("mid_load_data", 32'(data), 32'd3);
    valid = 4'b0000;
    step();
    check("mid_hold_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data", 32'(data), 32'd0);
    check("mid_rst_src", 32'(src), 32'd0);
    #1 rst_n = 1'b1;

    // All requesting after reset: a,b,c,d,a.
    valid = 4'b1111; out_ready = 1'b1;
    #1;
    check("post_rst_oready", 32'(ready_o), 32'b0001);
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("rr_data%0d", i), 32'(data), 32'((i % 4) + 1));
      check($sformatf("rr_src%0d", i), 32'(src), 32'(i % 4));
    end

    // Backpressure for 3 cycles: word 1 held, no grants.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("bp_oready%0d", i), 32'(ready_o), 32'd0);
      step();
      check($sformatf("bp_data%0d", i), 32'(data), 32'd1);
      check($sformatf("bp_valid%0d", i), 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_oready", 32'(ready_o), 32'b0010);
    step();
    check("bp_next_data", 32'(data), 32'd2);
    check("bp_next_src", 32'(src), 32'd1);

    valid = 4'b0000;
    step();
    check("end_valid", 32'(out_valid), 32'd0);
    check("end_data", 32'(data), 32'd2);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
